// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX FIFO scheduler.
//   state_t     - scheduler states (3-bit encoding)
//   DEF_D_BITS  - default byte width
//   GAP_W       - width of the inter-byte gap counter
package uart_pkg;

    localparam int DEF_D_BITS = 8;
    localparam int GAP_W      = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        SEND = 3'd3,
        GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// uart_gap_timer: loadable down-counter that paces the idle gap after each
// transmitter launch.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   load        - capture load_val into the counter
//   load_val    - number of extra idle cycles
//   en          - counting enabled (scheduler is in its GAP state)
//   done        - high in the last enabled cycle (counter reached zero)
module uart_gap_timer
    import uart_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A load of N gives N+1 enabled cycles before done, so the gap is never
    // shorter than one cycle.
    assign done = en && (count == '0);

endmodule

// File: rtl/uart_tx_fifo_sched.sv
// uart_tx_fifo_sched: owns both ports of the UART TX data FIFO. Host bytes are
// written through a valid/ready handshake; queued bytes are read one at a time
// and launched into the transmitter. Read and write strobes are never asserted
// in the same cycle (read wins).
// Optional build macro: UART_TX_CTS_EN adds a cts input (2-flop synchronised)
// that must be high before a new byte is read from the FIFO.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   host_data/valid/ready   - host byte handshake
//   fifo_din, fifo_wr_en    - FIFO write port
//   fifo_rd_en, fifo_dout   - FIFO read port (dout registered, valid next cycle)
//   fifo_full, fifo_empty   - FIFO status flags
//   tx_data, tx_start       - launch request to the transmitter
//   tx_ready                - transmitter idle, launch accepted with tx_start
//   cts                     - clear-to-send (only with UART_TX_CTS_EN)
//   tx_count                - bytes launched, wraps modulo 2^CNT_BITS
module uart_tx_fifo_sched
    import uart_pkg::*;
#(
    parameter int D_BITS     = DEF_D_BITS,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [D_BITS-1:0]   host_data,
    input  logic                host_valid,
    output logic                host_ready,
    output logic [D_BITS-1:0]   fifo_din,
    output logic                fifo_wr_en,
    output logic                fifo_rd_en,
    input  logic [D_BITS-1:0]   fifo_dout,
    input  logic                fifo_full,
    input  logic                fifo_empty,
    output logic [D_BITS-1:0]   tx_data,
    output logic                tx_start,
    input  logic                tx_ready,
`ifdef UART_TX_CTS_EN
    input  logic                cts,
`endif
    output logic [CNT_BITS-1:0] tx_count
);

    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

    state_t state;
    state_t next_state;
    logic   cap_en;
    logic   cnt_inc;
    logic   gap_load;
    logic   gap_en;
    logic   gap_done;
    logic   cts_ok;

`ifdef UART_TX_CTS_EN
    logic cts_s1;
    logic cts_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_s1 <= 1'b0;
            cts_s2 <= 1'b0;
        end else begin
            cts_s1 <= cts;
            cts_s2 <= cts_s1;
        end
    end

    assign cts_ok = cts_s2;
`else
    assign cts_ok = 1'b1;
`endif

    // Write path. Blocking the host during RD keeps the FIFO from seeing
    // both strobes at once; it would favour the write and drop our read.
    assign host_ready = !fifo_full && (state != RD) && !reset;
    assign fifo_wr_en = host_valid && host_ready;
    assign fifo_din   = host_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        fifo_rd_en = 1'b0;
        tx_start   = 1'b0;
        cap_en     = 1'b0;
        cnt_inc    = 1'b0;
        gap_load   = 1'b0;
        gap_en     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && tx_ready && cts_ok) begin
                    next_state = RD;
                end
            end
            RD: begin
                fifo_rd_en = 1'b1;
                next_state = CAP;
            end
            CAP: begin
                // fifo_dout becomes valid the cycle after the read strobe.
                cap_en     = 1'b1;
                next_state = SEND;
            end
            SEND: begin
                tx_start = 1'b1;
                if (tx_ready) begin
                    cnt_inc    = 1'b1;
                    gap_load   = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                gap_en = 1'b1;
                if (gap_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data <= '0;
        end else if (cap_en) begin
            tx_data <= fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_count <= '0;
        end else if (cnt_inc) begin
            tx_count <= tx_count + CNT_BITS'(1);
        end
    end

    uart_gap_timer #(
        .W (GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .en       (gap_en),
        .done     (gap_done)
    );

endmodule

// File: tb/tb_uart_tx_fifo_sched.sv
// Testbench for uart_tx_fifo_sched: drives the scheduler against a small
// 8-deep FIFO model (write-favouring, registered read data) and checks
// handshake, launch ordering, gap timing and reset behaviour.
module tb_uart_tx_fifo_sched;

    localparam int DB    = 8;
    localparam int GAPC  = 3;
    localparam int CB    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] host_data = '0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [DB-1:0] fifo_din;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic [DB-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DB-1:0] tx_data;
    logic          tx_start;
    logic          tx_ready = 1'b0;
    logic [CB-1:0] tx_count;
`ifdef UART_TX_CTS_EN
    logic          cts = 1'b1;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int overlap = 0;
    logic [DB-1:0] lq[$];
    int            lcyc[$];

    always #5 clk = ~clk;

    uart_tx_fifo_sched #(
        .D_BITS     (DB),
        .GAP_CYCLES (GAPC),
        .CNT_BITS   (CB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_ready   (tx_ready),
`ifdef UART_TX_CTS_EN
        .cts        (cts),
`endif
        .tx_count   (tx_count)
    );

    // FIFO model: write wins when both strobes are present.
    logic [DB-1:0] mem [DEPTH];
    logic [2:0]    wp, rp;
    logic [3:0]    fcount;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wp <= '0; rp <= '0; fcount <= '0; fifo_dout <= '0;
        end else if (fifo_wr_en && fcount != DEPTH) begin
            mem[wp] <= fifo_din; wp <= wp + 3'd1; fcount <= fcount + 4'd1;
        end else if (fifo_rd_en && fcount != 0) begin
            fifo_dout <= mem[rp]; rp <= rp + 3'd1; fcount <= fcount - 4'd1;
        end
    end
    assign fifo_full  = (fcount == DEPTH);
    assign fifo_empty = (fcount == 0);

    // Launch monitor: records accepted launches with their cycle index.
    always @(posedge clk) begin
        if (!reset && tx_start && tx_ready) begin
            lq.push_back(tx_data);
            lcyc.push_back(cyc);
        end
        if (!reset && fifo_wr_en && fifo_rd_en) overlap <= overlap + 1;
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; host_valid = 1'b1; host_data = 8'hFF; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_host_ready", {31'd0, host_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_tx_count", {16'd0, tx_count}, 32'd0);
        next_cyc();
        reset = 1'b0; host_valid = 1'b0; host_data = 8'h00;
    endtask

    typedef struct {
        logic          hv;
        logic [DB-1:0] hd;
        logic          tr;
        logic          hr;
        logic          wr;
        logic          rd;
        logic          ts;
        logic [DB-1:0] txd;
        logic [CB-1:0] cnt;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int guard;
        int acc;
        int wcyc;
        int rdseen;

        //           hv  hd     tr   hr wr rd ts txd    cnt
        tbl[0]  = '{1, 8'hA5, 1,   1, 1, 0, 0, 8'h00, 0};  // write into empty FIFO
        tbl[1]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'h00, 0};  // IDLE decides
        tbl[2]  = '{1, 8'h99, 1,   0, 0, 1, 0, 8'h00, 0};  // RD blocks host
        tbl[3]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'h00, 0};  // CAP
        tbl[4]  = '{0, 8'h00, 1,   1, 0, 0, 1, 8'hA5, 0};  // SEND accepted
        tbl[5]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};  // GAP x4
        tbl[6]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};
        tbl[7]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};
        tbl[8]  = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};
        tbl[9]  = '{1, 8'h3C, 0,   1, 1, 0, 0, 8'hA5, 1};  // IDLE, empty, write
        tbl[10] = '{0, 8'h00, 0,   1, 0, 0, 0, 8'hA5, 1};  // tx not ready: hold
        tbl[11] = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};  // IDLE decides
        tbl[12] = '{1, 8'h77, 1,   0, 0, 1, 0, 8'hA5, 1};  // RD blocks host
        tbl[13] = '{0, 8'h00, 1,   1, 0, 0, 0, 8'hA5, 1};  // CAP
        tbl[14] = '{0, 8'h00, 0,   1, 0, 0, 1, 8'h3C, 1};  // SEND stalled
        tbl[15] = '{1, 8'hE1, 0,   1, 1, 0, 1, 8'h3C, 1};  // write during SEND
        tbl[16] = '{0, 8'h00, 1,   1, 0, 0, 1, 8'h3C, 1};  // accepted
        tbl[17] = '{0, 8'h00, 1,   1, 0, 0, 0, 8'h3C, 2};  // GAP
        tbl[18] = '{0, 8'h00, 1,   1, 0, 0, 0, 8'h3C, 2};

        // Table: single byte latency, RD blocking, stalled SEND.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            host_valid = tbl[i].hv; host_data = tbl[i].hd; tx_ready = tbl[i].tr;
            @(negedge clk);
            chk($sformatf("tbl%0d_host_ready", i), {31'd0, host_ready}, {31'd0, tbl[i].hr});
            chk($sformatf("tbl%0d_wr_en", i), {31'd0, fifo_wr_en}, {31'd0, tbl[i].wr});
            chk($sformatf("tbl%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].rd});
            chk($sformatf("tbl%0d_tx_start", i), {31'd0, tx_start}, {31'd0, tbl[i].ts});
            chk($sformatf("tbl%0d_tx_data", i), {24'd0, tx_data}, {24'd0, tbl[i].txd});
            chk($sformatf("tbl%0d_tx_count", i), {16'd0, tx_count}, {16'd0, tbl[i].cnt});
            next_cyc();
        end

        // Fill the FIFO with tx blocked, then drain in order.
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            host_valid = 1'b1; host_data = 8'(i + 1);
            @(negedge clk);
            chk($sformatf("fill%0d_wr_en", i), {31'd0, fifo_wr_en}, 32'd1);
            next_cyc();
        end
        host_data = 8'h09;
        @(negedge clk);
        chk("full_host_ready", {31'd0, host_ready}, 32'd0);
        chk("full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        next_cyc();
        host_valid = 1'b0;
        lq.delete(); lcyc.delete();
        tx_ready = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!fifo_rd_en && guard < 20);
        chk("full_rd_seen", {31'd0, fifo_rd_en}, 32'd1);
        next_cyc();
        @(negedge clk);
        chk("full_reassert", {31'd0, host_ready}, 32'd1);
        guard = 0;
        while (lq.size() < 8 && guard < 300) begin next_cyc(); guard++; end
        chk("drain_count", lq.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("drain_byte%0d", i), (i < lq.size()) ? {24'd0, lq[i]} : 32'hDEAD, 32'(i + 1));
        chk("drain_tx_count", {16'd0, tx_count}, 32'd8);

        // Continuous host_valid while draining: no overlap, no loss/dup.
        do_reset();
        tx_ready = 1'b1;
        lq.delete(); lcyc.delete();
        overlap = 0;
        acc = 0; guard = 0;
        while (acc < 20 && guard < 600) begin
            host_valid = 1'b1; host_data = 8'(8'h40 + acc);
            @(negedge clk);
            if (fifo_wr_en) acc++;
            next_cyc();
            guard++;
        end
        host_valid = 1'b0;
        chk("stream_accepted", acc, 32'd20);
        guard = 0;
        while (lq.size() < 20 && guard < 600) begin next_cyc(); guard++; end
        chk("stream_count", lq.size(), 32'd20);
        for (int i = 0; i < 20; i++)
            chk($sformatf("stream_byte%0d", i), (i < lq.size()) ? {24'd0, lq[i]} : 32'hDEAD, 32'(8'h40 + i));
        chk("stream_tx_count", {16'd0, tx_count}, 32'd20);
        chk("stream_overlap", overlap, 32'd0);

        // Gap spacing with GAP_CYCLES=3.
        do_reset();
        tx_ready = 1'b1;
        lq.delete(); lcyc.delete();
        wcyc = cyc;
        host_valid = 1'b1; host_data = 8'hC1;
        next_cyc();
        host_data = 8'hC2;
        next_cyc();
        host_valid = 1'b0;
        guard = 0;
        while (lq.size() < 2 && guard < 100) begin next_cyc(); guard++; end
        chk("gap_count", lq.size(), 32'd2);
        if (lq.size() >= 2) begin
            chk("gap_first_latency", lcyc[0] - wcyc, 32'd4);
            chk("gap_spacing", lcyc[1] - lcyc[0], 32'd8);
            chk("gap_byte0", {24'd0, lq[0]}, 32'hC1);
            chk("gap_byte1", {24'd0, lq[1]}, 32'hC2);
        end
        repeat (6) next_cyc();

        // Reset while SEND is stalled.
        host_valid = 1'b1; host_data = 8'h5A; tx_ready = 1'b1;
        next_cyc();
        host_valid = 1'b0;
        next_cyc();
        tx_ready = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!tx_start && guard < 20);
        chk("send_stall_start", {31'd0, tx_start}, 32'd1);
        chk("send_stall_data", {24'd0, tx_data}, 32'h5A);
        chk("send_stall_count", {16'd0, tx_count}, 32'd2);
        next_cyc();
        reset = 1'b1;
        #1;
        chk("midsend_tx_start", {31'd0, tx_start}, 32'd0);
        chk("midsend_tx_count", {16'd0, tx_count}, 32'd0);
        chk("midsend_host_ready", {31'd0, host_ready}, 32'd0);
        next_cyc();
        reset = 1'b0; tx_ready = 1'b1;
        rdseen = 0;
        repeat (10) begin
            @(negedge clk);
            if (fifo_rd_en) rdseen++;
        end
        chk("post_reset_no_rd", rdseen, 32'd0);

`ifdef UART_TX_CTS_EN
        // Clear-to-send gating through the 2-flop synchroniser.
        cts = 1'b0;
        do_reset();
        tx_ready = 1'b1;
        host_valid = 1'b1; host_data = 8'h55;
        next_cyc();
        host_valid = 1'b0;
        rdseen = 0;
        repeat (6) begin
            @(negedge clk);
            if (fifo_rd_en) rdseen++;
            next_cyc();
        end
        chk("cts_low_no_rd", rdseen, 32'd0);
        cts = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("cts_rise%0d_rd_en", k), {31'd0, fifo_rd_en}, (k == 3) ? 32'd1 : 32'd0);
            next_cyc();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
